inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 158 +++++++++++++++
 tb/tb_inst_loader.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Program loader: receives a length-prefixed big-endian byte stream and
// writes it as 32-bit words into the instruction memory while holding the CPU.
module inst_loader #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        COLLECT,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] count;
    logic [15:0] widx;
    logic [1:0]  bcnt;
    logic [31:0] word;
    logic [15:0] addr_q;
    logic [31:0] data_q;

    logic        accept;
    logic        restart;
    logic [15:0] full_count;
    logic [15:0] widx_next;

    // Handshake and helper terms shared by the FSM and the datapath
    always_comb begin
        accept     = byte_valid && byte_ready;
        restart    = start && ((state == IDLE) || (state == DONE) || (state == ERR));
        full_count = {count[15:8], byte_in};
        widx_next  = widx + 16'd1;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (restart) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (full_count == 16'd0)
                        next_state = DONE;
                    else if ({1'b0, full_count} > 17'(MEM_DEPTH))
                        next_state = ERR;
                    else
                        next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && (bcnt == 2'd3)) next_state = WRITE;
            end
            WRITE: begin
                if (widx_next == count)
                    next_state = DONE;
                else
                    next_state = COLLECT;
            end
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs decoded from state; address/data come from held registers
    always_comb begin
        byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == COLLECT);
        mem_write  = (state == WRITE);
        busy       = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == COLLECT) || (state == WRITE);
        done       = (state == DONE);
        error      = (state == ERR);
        mem_addr   = addr_q;
        mem_datain = data_q;
    end

    // Length capture, word assembly and memory-port registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            widx   <= '0;
            bcnt   <= '0;
            word   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (restart) begin
                        count <= '0;
                        widx  <= '0;
                        bcnt  <= '0;
                        word  <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) count[15:8] <= byte_in;
                end
                LEN_LO: begin
                    if (accept) count[7:0] <= byte_in;
                end
                COLLECT: begin
                    if (accept) begin
                        case (bcnt)
                            2'd0:    word[31:24] <= byte_in;
                            2'd1:    word[23:16] <= byte_in;
                            2'd2:    word[15:8]  <= byte_in;
                            default: word[7:0]   <= byte_in;
                        endcase
                        bcnt <= bcnt + 2'd1;
                        // Address/data are latched on the 4th byte so they are
                        // valid throughout WRITE and held afterwards.
                        if (bcnt == 2'd3) begin
                            addr_q <= widx;
                            data_q <= {word[31:8], byte_in};
                        end
                    end
                end
                WRITE: begin
                    widx <= widx_next;
                    bcnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized
// loads compared against a byte-stream reference model.
module tb_inst_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_datain;
    logic        busy;
    logic        done;
    logic        error;

    inst_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor state: everything observed on the falling edge
    int          cyc = 0;
    int          rdy_cnt = 0;
    int          acc_cyc[$];
    int          w_cyc[$];
    logic [15:0] w_addr[$];
    logic [31:0] w_data[$];

    // Reference model inputs/outputs
    logic [7:0]  prog[$];
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;

    always @(negedge clk) begin
        cyc++;
        if (byte_ready) rdy_cnt++;
        if (byte_ready && byte_valid) acc_cyc.push_back(cyc);
        if (mem_write) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(mem_addr);
            w_data.push_back(mem_datain);
        end
    end

    // Expected result of a program stream: length prefix then big-endian words
    function automatic void model();
        int cnt;
        exp_addr.delete();
        exp_data.delete();
        cnt = int'(prog[0]) * 256 + int'(prog[1]);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (cnt > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            exp_done = 1'b1;
            for (int i = 0; i < cnt; i++) begin
                exp_addr.push_back(16'(i));
                exp_data.push_back({prog[2+4*i], prog[3+4*i], prog[4+4*i], prog[5+4*i]});
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_cyc.delete();
        w_cyc.delete();
        w_addr.delete();
        w_data.delete();
        rdy_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int n;
        byte_valid = 1'b0;
        repeat (stall) step();
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 64) begin
            step();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte_ready=%b after %0d cycles, required 1", byte_ready, n);
        end
        step();
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic run_load(input int smin, input int smax);
        int nbytes;
        model();
        clear_mon();
        pulse_start();
        nbytes = (exp_err || exp_addr.size() == 0) ? 2 : prog.size();
        for (int i = 0; i < nbytes; i++)
            send_byte(prog[i], int'($urandom_range(smax, smin)));
        byte_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({byte_ready, mem_write, mem_addr, mem_datain, busy, done, error} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b %h %h %b%b%b, required all 0",
                     byte_ready, mem_write, mem_addr, mem_datain, busy, done, error);
        end
        byte_valid = 1'b1;
        start = 1'b1;
        step();
        step();
        checks++;
        if ({byte_ready, mem_write, busy, done, error} !== 5'd0) begin
            errors++;
            $display("FAIL reset_held: got ready=%b wr=%b busy=%b done=%b err=%b, required all 0",
                     byte_ready, mem_write, busy, done, error);
        end
        start = 1'b0;
        reset = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({byte_ready, busy, done, error} !== 4'd0 || acc_cyc.size() != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b done=%b err=%b acc=%0d, required idle, 0 accepted",
                     byte_ready, busy, done, error, acc_cyc.size());
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_nominal();
        prog = '{8'h00, 8'h02, 8'h6F, 8'h7A, 8'h00, 8'h0A, 8'hD8, 8'h3B, 8'hC0, 8'h00};
        run_load(0, 0);
        checks++;
        if (w_addr.size() != 2) begin
            errors++;
            $display("FAIL nominal_wr_count: got %0d writes, required 2", w_addr.size());
        end
        if (w_addr.size() >= 2) begin
            checks++;
            if (w_addr[0] !== 16'd0 || w_data[0] !== 32'h6F7A000A) begin
                errors++;
                $display("FAIL nominal_word0: got %h/%h, required 0000/6f7a000a", w_addr[0], w_data[0]);
            end
            checks++;
            if (w_addr[1] !== 16'd1 || w_data[1] !== 32'hD83BC000) begin
                errors++;
                $display("FAIL nominal_word1: got %h/%h, required 0001/d83bc000", w_addr[1], w_data[1]);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL nominal_status: got done=%b busy=%b err=%b, required 1 0 0", done, busy, error);
        end
        checks++;
        if (rdy_cnt != 10) begin
            errors++;
            $display("FAIL nominal_ready_cycles: got %0d, required 10", rdy_cnt);
        end
    endtask

    task automatic test_stalled();
        prog = '{8'h00, 8'h02, 8'h6F, 8'h7A, 8'h00, 8'h0A, 8'hD8, 8'h3B, 8'hC0, 8'h00};
        run_load(3, 3);
        checks++;
        if (w_addr.size() != 2 || acc_cyc.size() != 10) begin
            errors++;
            $display("FAIL stall_counts: got %0d writes %0d accepts, required 2 and 10",
                     w_addr.size(), acc_cyc.size());
        end
        if (w_addr.size() >= 2) begin
            checks++;
            if (w_addr[0] !== 16'd0 || w_data[0] !== 32'h6F7A000A ||
                w_addr[1] !== 16'd1 || w_data[1] !== 32'hD83BC000) begin
                errors++;
                $display("FAIL stall_data: got %h/%h %h/%h, required 0000/6f7a000a 0001/d83bc000",
                         w_addr[0], w_data[0], w_addr[1], w_data[1]);
            end
        end
        for (int k = 0; k < w_cyc.size() && (5 + 4*k) < acc_cyc.size(); k++) begin
            checks++;
            if (w_cyc[k] != acc_cyc[5+4*k] + 1) begin
                errors++;
                $display("FAIL stall_latency%0d: write at cycle %0d, required %0d",
                         k, w_cyc[k], acc_cyc[5+4*k] + 1);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_status: got done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_boundary();
        // zero-length program
        prog = '{8'h00, 8'h00};
        run_load(0, 1);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || w_addr.size() != 0) begin
            errors++;
            $display("FAIL bound_zero: got done=%b err=%b writes=%0d, required 1 0 0",
                     done, error, w_addr.size());
        end
        // one word over capacity
        prog = '{8'h01, 8'h01};
        run_load(0, 1);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || w_addr.size() != 0) begin
            errors++;
            $display("FAIL bound_over: got err=%b done=%b busy=%b writes=%0d, required 1 0 0 0",
                     error, done, busy, w_addr.size());
        end
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        repeat (4) step();
        checks++;
        if (byte_ready !== 1'b0 || acc_cyc.size() != 2 || error !== 1'b1) begin
            errors++;
            $display("FAIL bound_over_hold: got ready=%b accepts=%0d err=%b, required 0 2 1",
                     byte_ready, acc_cyc.size(), error);
        end
        byte_valid = 1'b0;
        // exactly full memory
        prog = '{8'h01, 8'h00};
        for (int i = 0; i < 4 * DEPTH; i++) prog.push_back(8'($urandom));
        run_load(0, 0);
        checks++;
        if (w_addr.size() != DEPTH || done !== 1'b1) begin
            errors++;
            $display("FAIL bound_full_count: got %0d writes done=%b, required %0d and 1",
                     w_addr.size(), done, DEPTH);
        end
        for (int k = 0; k < w_addr.size() && k < exp_addr.size(); k++) begin
            checks++;
            if (w_addr[k] !== exp_addr[k] || w_data[k] !== exp_data[k]) begin
                errors++;
                $display("FAIL bound_full_word%0d: got %h/%h, required %h/%h",
                         k, w_addr[k], w_data[k], exp_addr[k], exp_data[k]);
            end
        end
        if (w_addr.size() > 0) begin
            checks++;
            if (w_addr[w_addr.size()-1] !== 16'd255) begin
                errors++;
                $display("FAIL bound_full_last: got addr %h, required 00ff", w_addr[w_addr.size()-1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        prog = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_mon();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({byte_ready, mem_write, mem_addr, mem_datain, busy, done, error} !== 53'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b%b %h %h %b%b%b, required all 0",
                     byte_ready, mem_write, mem_addr, mem_datain, busy, done, error);
        end
        byte_valid = 1'b1;
        byte_in    = 8'h99;
        repeat (3) step();
        byte_valid = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (w_addr.size() != 1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got writes=%0d busy=%b done=%b, required 1 0 0",
                     w_addr.size(), busy, done);
        end
        if (w_addr.size() >= 1) begin
            checks++;
            if (w_addr[0] !== 16'd0 || w_data[0] !== 32'h11223344) begin
                errors++;
                $display("FAIL midreset_word0: got %h/%h, required 0000/11223344", w_addr[0], w_data[0]);
            end
        end
        prog = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load(0, 0);
        checks++;
        if (w_addr.size() != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload_count: got writes=%0d done=%b, required 1 1", w_addr.size(), done);
        end
        if (w_addr.size() >= 1) begin
            checks++;
            if (w_addr[0] !== 16'd0 || w_data[0] !== 32'h01020304) begin
                errors++;
                $display("FAIL midreset_reload: got %h/%h, required 0000/01020304", w_addr[0], w_data[0]);
            end
        end
    endtask

    task automatic test_random();
        int kind;
        int cnt;
        for (int it = 0; it < 10; it++) begin
            kind = int'($urandom_range(9, 0));
            if (kind == 0)      cnt = 0;
            else if (kind == 1) cnt = DEPTH + 1 + int'($urandom_range(500, 0));
            else                cnt = int'($urandom_range(6, 1));
            prog.delete();
            prog.push_back(8'(cnt >> 8));
            prog.push_back(8'(cnt));
            if (cnt <= DEPTH)
                for (int i = 0; i < 4 * cnt; i++) prog.push_back(8'($urandom));
            run_load(0, 2);
            checks++;
            if (done !== exp_done || error !== exp_err || busy !== 1'b0 ||
                w_addr.size() != exp_addr.size()) begin
                errors++;
                $display("FAIL rand%0d_status: got done=%b err=%b busy=%b writes=%0d, required %b %b 0 %0d",
                         it, done, error, busy, w_addr.size(), exp_done, exp_err, exp_addr.size());
            end
            for (int k = 0; k < w_addr.size() && k < exp_addr.size(); k++) begin
                checks++;
                if (w_addr[k] !== exp_addr[k] || w_data[k] !== exp_data[k]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got %h/%h, required %h/%h",
                             it, k, w_addr[k], w_data[k], exp_addr[k], exp_data[k]);
                end
                if ((5 + 4*k) < acc_cyc.size()) begin
                    checks++;
                    if (w_cyc[k] != acc_cyc[5+4*k] + 1) begin
                        errors++;
                        $display("FAIL rand%0d_latency%0d: write at cycle %0d, required %0d",
                                 it, k, w_cyc[k], acc_cyc[5+4*k] + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        prog = '{8'h00, 8'h02};
        for (int i = 0; i < 8; i++) prog.push_back(8'($urandom));
        model();
        clear_mon();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(prog[i], 0);
        pulse_start();
        for (int i = 4; i < 10; i++) send_byte(prog[i], 0);
        wait_idle();
        checks++;
        if (w_addr.size() != 2 || done !== 1'b1) begin
            errors++;
            $display("FAIL ignstart_count: got writes=%0d done=%b, required 2 1", w_addr.size(), done);
        end
        for (int k = 0; k < w_addr.size() && k < exp_addr.size(); k++) begin
            checks++;
            if (w_addr[k] !== exp_addr[k] || w_data[k] !== exp_data[k]) begin
                errors++;
                $display("FAIL ignstart_word%0d: got %h/%h, required %h/%h",
                         k, w_addr[k], w_data[k], exp_addr[k], exp_data[k]);
            end
        end
        step();
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: got done=%b busy=%b ready=%b, required 0 1 1",
                     done, busy, byte_ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stalled();
        test_boundary();
        test_reset_midload();
        test_random();
        test_ignored_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
